// File: rtl/ifu_pkg.sv
// Shared types and constants for the LemonPC instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } ifu_state_e;

  localparam logic [63:0] IFU_PC_INIT  = 64'h8000_0000;
  localparam int          IFU_INST_LEN = 4;

  // Pick the 32-bit instruction out of the fetched doubleword.
  function automatic logic [31:0] word_sel(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

  function automatic logic is_misaligned(input logic [63:0] addr, input int len);
    return (addr & 64'(len - 1)) != 64'd0;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready bus and
// hands one instruction at a time to the datapath.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [63:0] PC_INIT  = IFU_PC_INIT,
  parameter int          INST_LEN = IFU_INST_LEN
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_misalign,
  input  logic        inst_ready,
  input  logic [63:0] next_pc,
  output logic [63:0] retire_cnt
);

  ifu_state_e  state;
  logic [63:0] pc;
  logic [31:0] inst_q;
  logic        fault_q;
  logic        misalign_q;

  // Outputs come straight from state and registers; no input feeds through.
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = {pc[63:3], 3'b000};
  assign inst_valid    = (state == S_HOLD);
  assign inst          = inst_q;
  assign inst_pc       = pc;
  assign inst_fault    = fault_q;
  assign inst_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= PC_INIT;
      retire_cnt <= '0;
      inst_q     <= '0;
      fault_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            inst_q  <= mem_resp_err ? 32'd0 : word_sel(mem_resp_data, pc[2]);
            fault_q <= mem_resp_err;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc         <= next_pc;
            retire_cnt <= retire_cnt + 64'd1;
            fault_q    <= 1'b0;
            // A misaligned target never reaches the bus; it is presented
            // directly so the datapath can trap and redirect.
            if (is_misaligned(next_pc, INST_LEN)) begin
              misalign_q <= 1'b1;
              inst_q     <= '0;
            end else begin
              misalign_q <= 1'b0;
              state      <= S_REQ;
            end
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed test-plan steps followed by random
// fetch/consume traffic against a small behavioural model.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        inst_misalign;
  logic        inst_ready;
  logic [63:0] next_pc;
  logic [63:0] retire_cnt;

  ifu dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .inst_misalign(inst_misalign),
    .inst_ready(inst_ready), .next_pc(next_pc), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: architectural PC, retired count, presented instruction.
  logic [63:0] m_pc;
  logic [63:0] m_cnt;
  logic [31:0] m_inst;
  logic        m_fault;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] dw_addr(input logic [63:0] a);
    return a - (a % 64'd8);
  endfunction

  function automatic logic [31:0] pick(input logic [63:0] a, input logic [63:0] d);
    return ((a % 64'd8) >= 64'd4) ? d[63:32] : d[31:0];
  endfunction

  // Model a memory: stall the request, accept it, delay, then respond.
  task automatic fetch(input logic [63:0] data, input logic err,
                       input int req_wait, input int resp_wait);
    for (int i = 0; i < req_wait; i++) begin
      chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_req_addr", mem_req_addr, dw_addr(m_pc));
      step();
    end
    mem_req_ready = 1'b1;
    chk("req_valid", 64'(mem_req_valid), 64'd1);
    chk("req_addr", mem_req_addr, dw_addr(m_pc));
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      chk("wait_req_valid", 64'(mem_req_valid), 64'd0);
      chk("wait_inst_valid", 64'(inst_valid), 64'd0);
      step();
    end
    chk("wait_no_dup_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_resp_data  = {$urandom, $urandom};
    m_inst  = err ? 32'd0 : pick(m_pc, data);
    m_fault = err;
    chk("inst_valid", 64'(inst_valid), 64'd1);
    chk("inst", 64'(inst), 64'(m_inst));
    chk("inst_pc", inst_pc, m_pc);
    chk("inst_fault", 64'(inst_fault), 64'(m_fault));
    chk("inst_misalign", 64'(inst_misalign), 64'd0);
  endtask

  // Downstream holds off for some cycles, then consumes with the given dnpc.
  task automatic consume(input logic [63:0] npc, input int hold);
    for (int i = 0; i < hold; i++) begin
      next_pc = {$urandom, $urandom};
      chk("hold_inst_valid", 64'(inst_valid), 64'd1);
      chk("hold_inst", 64'(inst), 64'(m_inst));
      chk("hold_inst_pc", inst_pc, m_pc);
      step();
    end
    inst_ready = 1'b1;
    next_pc    = npc;
    step();
    inst_ready = 1'b0;
    next_pc    = {$urandom, $urandom};
    m_pc  = npc;
    m_cnt = m_cnt + 64'd1;
    m_fault = 1'b0;
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("inst_pc_after", inst_pc, m_pc);
    chk("fault_cleared", 64'(inst_fault), 64'd0);
    if (npc % 64'd4 != 64'd0) begin
      m_inst = 32'd0;
      chk("mis_valid", 64'(inst_valid), 64'd1);
      chk("mis_flag", 64'(inst_misalign), 64'd1);
      chk("mis_inst", 64'(inst), 64'd0);
      chk("mis_no_req", 64'(mem_req_valid), 64'd0);
    end else begin
      chk("next_req_valid", 64'(mem_req_valid), 64'd1);
      chk("next_inst_valid", 64'(inst_valid), 64'd0);
      chk("next_misalign", 64'(inst_misalign), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] npc;
    rst = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    mem_resp_err = 1'b0; inst_ready = 1'b0; next_pc = '0;
    m_pc = 64'h8000_0000; m_cnt = '0; m_inst = '0; m_fault = 1'b0;

    // Reset held for two edges, then check the first post-reset cycle.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd1);
    chk("rst_req_addr", mem_req_addr, 64'h8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_fault", 64'(inst_fault), 64'd0);
    chk("rst_misalign", 64'(inst_misalign), 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);

    // Lower word, zero-wait memory.
    fetch(64'h00000013_00100073, 1'b0, 0, 0);
    chk("lower_inst", 64'(inst), 64'h0010_0073);
    // Upper word from the same doubleword, then 5 cycles of backpressure.
    consume(64'h8000_0004, 0);
    fetch(64'h00000013_00100073, 1'b0, 0, 0);
    chk("upper_inst", 64'(inst), 64'h0000_0013);
    consume(64'h8000_0008, 5);
    chk("retire_two", retire_cnt, 64'd2);

    // Slow memory, then an access fault.
    fetch(64'hdead_beef_cafe_f00d, 1'b1, 3, 2);
    chk("fault_inst_zero", 64'(inst), 64'd0);
    chk("fault_flag", 64'(inst_fault), 64'd1);

    // Misaligned redirect, then recovery fetch.
    consume(64'h8000_0102, 1);
    consume(64'h8000_0200, 2);
    chk("redirect_addr", mem_req_addr, 64'h8000_0200);
    fetch(64'h1111_2222_3333_4444, 1'b0, 1, 1);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = int'($urandom_range(0, 5));
      if (sel == 0)      npc = m_pc + 64'd4;
      else if (sel == 1) npc = {32'h0, $urandom} | 64'h1;
      else if (sel == 2) npc = {32'h0, $urandom} & ~64'h3 | 64'h2;
      else               npc = {$urandom, $urandom} & ~64'h3;
      consume(npc, int'($urandom_range(0, 3)));
      while (m_pc % 64'd4 != 64'd0)
        consume({$urandom, $urandom} & ~64'h3, int'($urandom_range(0, 2)));
      fetch({$urandom, $urandom}, ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset while waiting for a response.
    consume(64'h9000_0010, 0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("pre_rst_wait", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_pc = 64'h8000_0000; m_cnt = '0;
    chk("rst_wait_req_valid", 64'(mem_req_valid), 64'd1);
    chk("rst_wait_req_addr", mem_req_addr, 64'h8000_0000);
    chk("rst_wait_retire", retire_cnt, 64'd0);
    chk("rst_wait_inst_valid", 64'(inst_valid), 64'd0);
    fetch(64'h0000_0001_0000_0002, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
